ask_demodulator: RTL and testbench

- Receive-side counterpart of ASK_modulator: recovers the binary modulating stream from a 12-bit signed ASK waveform, such as the DDS sin/cos/squ/saw outputs gated by the modulator bit.
- Per-window peak envelope detection with hysteresis thresholding produces an envelope bit; a window-count bit synchroniser then samples it mid-bit.
- Sits after the DDS/ASK chain (loopback test) or after an ADC front-end; output drives the LED/logic-analyser path.

---
 rtl/ask_demod_pkg.sv | 14 +
 rtl/ask_peak_detector.sv | 86 ++++++++
 rtl/ask_demodulator.sv | 164 ++++++++++++++++
 tb/tb_ask_demodulator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ask_demod_pkg.sv
// Shared constants and types for the ASK demodulator: default sample widths,
// the saturated magnitude value and the bit-synchroniser state encoding.
package ask_demod_pkg;

    localparam int ASK_DATA_W = 12;
    localparam int ASK_MAG_W  = ASK_DATA_W - 1;
    localparam logic [ASK_MAG_W-1:0] ASK_MAG_SAT = 11'd2047;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } sync_state_t;

endpackage

// File: rtl/ask_peak_detector.sv
// Per-window peak envelope detector: saturating |x|, window counter and running
// max. Exposes the closing-sample max combinationally so hysteresis lands at t+1.
module ask_peak_detector
    import ask_demod_pkg::*;
#(
    parameter int DATA_W = ASK_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] ask_in,
    input  logic [CNT_W-1:0]  win_len,
    output logic              win_last,
    output logic [DATA_W-2:0] win_max,
    output logic [DATA_W-2:0] peak_out,
    output logic              win_done
);

    localparam int MAG_W = DATA_W - 1;

    logic [DATA_W-1:0] neg;
    logic [MAG_W-1:0]  mag;
    logic [CNT_W-1:0]  win_len_m1;

    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [MAG_W-1:0] acc_q, acc_d;
    logic [MAG_W-1:0] peak_q, peak_d;
    logic             win_done_q, win_done_d;

    always_comb begin
        neg = -ask_in;
        if (ask_in[DATA_W-1]) begin
            // negating the most negative code wraps back to negative: saturate
            if (neg[DATA_W-1]) begin
                mag = '1;
            end else begin
                mag = neg[MAG_W-1:0];
            end
        end else begin
            mag = ask_in[MAG_W-1:0];
        end
    end

    always_comb begin
        win_len_m1 = (win_len == '0) ? '0 : win_len - CNT_W'(1);
        win_last   = en && (win_cnt_q >= win_len_m1);
        win_max    = (mag > acc_q) ? mag : acc_q;
    end

    always_comb begin
        win_cnt_d  = win_cnt_q;
        acc_d      = acc_q;
        peak_d     = peak_q;
        win_done_d = 1'b0;
        if (en) begin
            if (win_last) begin
                win_cnt_d  = '0;
                acc_d      = '0;
                peak_d     = win_max;
                win_done_d = 1'b1;
            end else begin
                win_cnt_d  = win_cnt_q + CNT_W'(1);
                acc_d      = win_max;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_q  <= '0;
            acc_q      <= '0;
            peak_q     <= '0;
            win_done_q <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            acc_q      <= acc_d;
            peak_q     <= peak_d;
            win_done_q <= win_done_d;
        end
    end

    assign peak_out = peak_q;
    assign win_done = win_done_q;

endmodule

// File: rtl/ask_demodulator.sv
// ASK demodulator top: hysteresis thresholding of window peaks into env_bit and
// a window-count bit synchroniser that samples env_bit mid-bit.
//
// state | meaning
// HUNT  | unlocked, waiting for an envelope transition to align on
// SYNC  | counting windows per bit, emitting env_bit at mid-bit
module ask_demodulator
    import ask_demod_pkg::*;
#(
    parameter int DATA_W       = ASK_DATA_W,
    parameter int CNT_W        = 16,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] ask_in,
    input  logic [CNT_W-1:0]  win_len,
    input  logic [CNT_W-1:0]  bit_len,
    input  logic [DATA_W-2:0] thr_hi,
    input  logic [DATA_W-2:0] thr_lo,
    output logic [DATA_W-2:0] peak_out,
    output logic              env_bit,
    output logic              data_out,
    output logic              data_valid,
    output logic              locked
);

    localparam int QW = $clog2(LOCK_TIMEOUT + 1);

    logic              win_last;
    logic [DATA_W-2:0] win_max;
    logic              win_done;

    ask_peak_detector #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_peak (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ask_in   (ask_in),
        .win_len  (win_len),
        .win_last (win_last),
        .win_max  (win_max),
        .peak_out (peak_out),
        .win_done (win_done)
    );

    sync_state_t      state_q, state_d;
    logic             env_bit_q, env_bit_d;
    logic             env_prev_q, env_prev_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [QW-1:0]    quiet_cnt_q, quiet_cnt_d;
    logic             edge_seen_q, edge_seen_d;
    logic             data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             locked_q, locked_d;

    logic [CNT_W-1:0] bit_len_eff;
    logic [CNT_W-1:0] bit_half;
    logic             env_edge;
    logic [QW-1:0]    quiet_next;

    always_comb begin
        env_bit_d = env_bit_q;
        // thr_hi checked first so it wins when thresholds are inverted
        if (win_last) begin
            if (win_max >= thr_hi) begin
                env_bit_d = 1'b1;
            end else if (win_max < thr_lo) begin
                env_bit_d = 1'b0;
            end
        end
    end

    always_comb begin
        bit_len_eff = (bit_len == '0) ? CNT_W'(1) : bit_len;
        bit_half    = (bit_len[CNT_W-1:1] == '0) ? CNT_W'(1) : {1'b0, bit_len[CNT_W-1:1]};
        env_edge    = win_done && (env_bit_q != env_prev_q);
        quiet_next  = edge_seen_q ? '0 : quiet_cnt_q + QW'(1);
    end

    always_comb begin
        state_d      = state_q;
        env_prev_d   = env_prev_q;
        bit_cnt_d    = bit_cnt_q;
        quiet_cnt_d  = quiet_cnt_q;
        edge_seen_d  = edge_seen_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        locked_d     = locked_q;

        if (win_done) begin
            env_prev_d = env_bit_q;
        end

        case (state_q)
            HUNT: begin
                locked_d = 1'b0;
                if (env_edge) begin
                    bit_cnt_d   = bit_half;
                    quiet_cnt_d = '0;
                    edge_seen_d = 1'b0;
                    state_d     = SYNC;
                end
            end
            SYNC: begin
                if (win_done) begin
                    if (env_edge) begin
                        bit_cnt_d   = bit_half;
                        edge_seen_d = 1'b1;
                    end else if (bit_cnt_q <= CNT_W'(1)) begin
                        data_out_d   = env_bit_q;
                        data_valid_d = 1'b1;
                        bit_cnt_d    = bit_len_eff;
                        edge_seen_d  = 1'b0;
                        if (quiet_next >= QW'(LOCK_TIMEOUT)) begin
                            quiet_cnt_d = '0;
                            locked_d    = 1'b0;
                            state_d     = HUNT;
                        end else begin
                            quiet_cnt_d = quiet_next;
                            locked_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            env_bit_q    <= 1'b0;
            env_prev_q   <= 1'b0;
            bit_cnt_q    <= '0;
            quiet_cnt_q  <= '0;
            edge_seen_q  <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            env_bit_q    <= env_bit_d;
            env_prev_q   <= env_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            quiet_cnt_q  <= quiet_cnt_d;
            edge_seen_q  <= edge_seen_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
        end
    end

    assign env_bit    = env_bit_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_ask_demodulator.sv
// Self-checking bench for ask_demodulator: table-driven window/hysteresis
// vectors plus scoreboarded bit-recovery sequences.
`timescale 1ns/1ps
module tb_ask_demodulator;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 16;
    localparam int MAG_W  = DATA_W - 1;

    logic              clk;
    logic              reset;
    logic              en;
    logic [DATA_W-1:0] ask_in;
    logic [CNT_W-1:0]  win_len;
    logic [CNT_W-1:0]  bit_len;
    logic [MAG_W-1:0]  thr_hi;
    logic [MAG_W-1:0]  thr_lo;
    logic [MAG_W-1:0]  peak_out;
    logic              env_bit;
    logic              data_out;
    logic              data_valid;
    logic              locked;

    ask_demodulator #(
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ask_in     (ask_in),
        .win_len    (win_len),
        .bit_len    (bit_len),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .peak_out   (peak_out),
        .env_bit    (env_bit),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked)
    );

    typedef struct {
        int sample;
        int hi;
        int lo;
        int exp_peak;
        int exp_env;
    } hys_vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit exp_q[$];
    int vt[$];
    logic prev_dv = 1'b0;
    int sine [8] = '{0, 707, 1000, 707, 0, -707, -1000, -707};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: every data_valid pops one expected bit
    always @(negedge clk) begin
        if (reset && data_valid) begin
            check("dv_not_back_to_back", int'(prev_dv), 0);
            vt.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_data_valid", 1, 0);
            end else begin
                check("data_out", int'(data_out), int'(exp_q.pop_front()));
            end
        end
        prev_dv = data_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int v);
        @(negedge clk);
        ask_in = v[DATA_W-1:0];
        en     = 1'b1;
    endtask

    task automatic run_window(input int v, input int n);
        for (int i = 0; i < n; i++) drive(v);
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        #1;
        check("rst_peak_out", int'(peak_out), 0);
        check("rst_env_bit", int'(env_bit), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_locked", int'(locked), 0);
        repeat (3) @(negedge clk);
        check("rst_hold_dv", int'(data_valid), 0);
        check("rst_hold_peak", int'(peak_out), 0);
        exp_q.delete();
        vt.delete();
        reset = 1'b1;
    endtask

    task automatic set_thr(input int hi, input int lo);
        thr_hi = hi[MAG_W-1:0];
        thr_lo = lo[MAG_W-1:0];
    endtask

    hys_vec_t tbl [12];

    initial begin
        tbl[0]  = '{700,   600, 300, 700,  1};
        tbl[1]  = '{450,   600, 300, 450,  1};
        tbl[2]  = '{250,   600, 300, 250,  0};
        tbl[3]  = '{450,   600, 300, 450,  0};
        tbl[4]  = '{600,   600, 300, 600,  1};
        tbl[5]  = '{300,   600, 300, 300,  1};
        tbl[6]  = '{299,   600, 300, 299,  0};
        tbl[7]  = '{-1000, 600, 300, 1000, 1};
        tbl[8]  = '{0,     600, 300, 0,    0};
        tbl[9]  = '{600,   500, 800, 600,  1};
        tbl[10] = '{400,   500, 800, 400,  0};
        tbl[11] = '{2047,  600, 300, 2047, 1};

        reset   = 1'b0;
        en      = 1'b0;
        ask_in  = '0;
        win_len = 16'd4;
        bit_len = 16'd1000;
        set_thr(600, 300);
        do_reset();

        // saturation of the most negative code, with window latency
        win_len = 16'd4;
        for (int i = 0; i < 3; i++) drive(-2048);
        @(negedge clk);
        check("sat_peak_before_close", int'(peak_out), 0);
        ask_in = 12'h800;
        @(negedge clk);
        en = 1'b0;
        check("sat_peak", int'(peak_out), 2047);
        check("sat_env", int'(env_bit), 1);

        // reset in the middle of a window, then clean restart
        win_len = 16'd8;
        for (int i = 0; i < 5; i++) drive(1500);
        do_reset();
        win_len = 16'd4;
        run_window(300, 4);
        check("restart_peak", int'(peak_out), 300);
        check("restart_env", int'(env_bit), 0);

        // hysteresis table
        win_len = 16'd8;
        for (int i = 0; i < 12; i++) begin
            set_thr(tbl[i].hi, tbl[i].lo);
            run_window(tbl[i].sample, 8);
            check($sformatf("hys_peak[%0d]", i), int'(peak_out), tbl[i].exp_peak);
            check($sformatf("hys_env[%0d]", i), int'(env_bit), tbl[i].exp_env);
        end

        // win_len = 0 behaves as one sample per window
        set_thr(600, 300);
        win_len = 16'd0;
        run_window(700, 1);
        check("wl0_peak_a", int'(peak_out), 700);
        check("wl0_env_a", int'(env_bit), 1);
        run_window(100, 1);
        check("wl0_peak_b", int'(peak_out), 100);
        check("wl0_env_b", int'(env_bit), 0);

        // shrinking win_len mid-window closes on the current sample
        win_len = 16'd8;
        run_window(150, 5);
        check("wlchg_still_open", int'(peak_out), 100);
        win_len = 16'd4;
        run_window(900, 1);
        check("wlchg_closed_peak", int'(peak_out), 900);
        check("wlchg_env", int'(env_bit), 1);

        // loopback of pattern 10110010, one carrier period per window
        do_reset();
        win_len = 16'd8;
        bit_len = 16'd4;
        set_thr(600, 300);
        begin
            bit pat [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
            for (int b = 0; b < 8; b++) begin
                exp_q.push_back(pat[b]);
                for (int w = 0; w < 4; w++)
                    for (int k = 0; k < 8; k++)
                        drive(pat[b] ? sine[k] : 0);
            end
        end
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("loop_dv_count", vt.size(), 8);
        for (int i = 1; i < vt.size(); i++)
            check($sformatf("loop_dv_gap[%0d]", i), vt[i] - vt[i-1], 32);
        check("loop_all_bits_seen", exp_q.size(), 0);
        check("loop_locked", int'(locked), 1);

        // constant carrier: lock drops after 16 quiet bits
        do_reset();
        win_len = 16'd8;
        bit_len = 16'd4;
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b1);
        for (int w = 0; w < 80; w++) begin
            for (int k = 0; k < 8; k++) begin
                if (w == 20 && k == 0) begin
                    @(negedge clk);
                    check("to_locked_mid", int'(locked), 1);
                    ask_in = sine[0][DATA_W-1:0];
                end else begin
                    drive(sine[k]);
                end
            end
        end
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("to_dv_count", vt.size(), 16);
        if (vt.size() == 16) check("to_dv_span", vt[15] - vt[0], 15 * 32);
        check("to_all_bits_seen", exp_q.size(), 0);
        check("to_unlocked", int'(locked), 0);

        // envelope edge on the expiry window wins; next bit 2 windows later
        do_reset();
        win_len = 16'd8;
        bit_len = 16'd4;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int w = 0; w < 12; w++)
            for (int k = 0; k < 8; k++)
                drive(w < 6 ? sine[k] : 0);
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("col_dv_count", vt.size(), 2);
        if (vt.size() == 2) check("col_dv_gap", vt[1] - vt[0], 48);
        check("col_all_bits_seen", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
